ttl_gen_axi_lite_slave: RTL and testbench



---
 rtl/ttl_gen_axi_pkg.sv | 47 ++++
 rtl/ttl_gen_axi_regfile.sv | 87 ++++++++
 rtl/ttl_gen_axi_lite_slave.sv | 170 +++++++++++++++++
 tb/tb_ttl_gen_axi_lite_slave.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ttl_gen_axi_pkg.sv
// rtl/ttl_gen_axi_pkg.sv - shared constants, FSM state types and helpers for the TTL generator AXI4-Lite slave
package ttl_gen_axi_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_PERIOD   = 3'd2;
    localparam logic [2:0] REG_HIGH     = 3'd3;
    localparam logic [2:0] REG_COUNT    = 3'd4;
    localparam logic [2:0] REG_SCRATCH0 = 3'd5;
    localparam logic [2:0] REG_SCRATCH1 = 3'd6;
    localparam logic [2:0] REG_SCRATCH2 = 3'd7;
    localparam int         NUM_REGS     = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_START_BIT = 1;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_e;

    // Word indices 0-7 live in the bank; 8-15 answer SLVERR.
    function automatic logic idx_mapped(input logic [3:0] idx);
        return (idx < 4'(NUM_REGS));
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ttl_gen_axi_regfile.sv
// rtl/ttl_gen_axi_regfile.sv - byte-strobed register bank, STATUS mux and start strobe for the TTL generator
module ttl_gen_axi_regfile
    import ttl_gen_axi_pkg::*;
#(
    parameter logic [31:0] PERIOD_RST = 32'd1000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_en_i,
    input  logic [2:0]  wr_idx_i,
    input  logic [31:0] wr_data_i,
    input  logic [3:0]  wr_strb_i,
    input  logic [2:0]  rd_idx_i,
    output logic [31:0] rd_data_o,
    input  logic        busy_i,
    input  logic        done_i,
    output logic        enable_o,
    output logic        start_o,
    output logic [31:0] period_o,
    output logic [31:0] high_o,
    output logic [31:0] count_o
);

    logic        ctrl_en_q;
    logic        start_q;
    logic [31:0] period_q;
    logic [31:0] high_q;
    logic [31:0] count_q;
    logic [31:0] scratch0_q;
    logic [31:0] scratch1_q;
    logic [31:0] scratch2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_en_q  <= 1'b0;
            start_q    <= 1'b0;
            period_q   <= PERIOD_RST;
            high_q     <= '0;
            count_q    <= '0;
            scratch0_q <= '0;
            scratch1_q <= '0;
            scratch2_q <= '0;
        end else begin
            start_q <= 1'b0;
            if (wr_en_i) begin
                case (wr_idx_i)
                    REG_CTRL: begin
                        // Start is self-clearing: it only exists as the strobe.
                        if (wr_strb_i[0]) begin
                            ctrl_en_q <= wr_data_i[CTRL_EN_BIT];
                            start_q   <= wr_data_i[CTRL_START_BIT];
                        end
                    end
                    REG_PERIOD:   period_q   <= apply_strb(period_q, wr_data_i, wr_strb_i);
                    REG_HIGH:     high_q     <= apply_strb(high_q, wr_data_i, wr_strb_i);
                    REG_COUNT:    count_q    <= apply_strb(count_q, wr_data_i, wr_strb_i);
                    REG_SCRATCH0: scratch0_q <= apply_strb(scratch0_q, wr_data_i, wr_strb_i);
                    REG_SCRATCH1: scratch1_q <= apply_strb(scratch1_q, wr_data_i, wr_strb_i);
                    REG_SCRATCH2: scratch2_q <= apply_strb(scratch2_q, wr_data_i, wr_strb_i);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        case (rd_idx_i)
            REG_CTRL:     rd_data_o = {31'b0, ctrl_en_q};
            REG_STATUS:   rd_data_o = {30'b0, done_i, busy_i};
            REG_PERIOD:   rd_data_o = period_q;
            REG_HIGH:     rd_data_o = high_q;
            REG_COUNT:    rd_data_o = count_q;
            REG_SCRATCH0: rd_data_o = scratch0_q;
            REG_SCRATCH1: rd_data_o = scratch1_q;
            REG_SCRATCH2: rd_data_o = scratch2_q;
            default:      rd_data_o = '0;
        endcase
    end

    assign enable_o = ctrl_en_q;
    assign start_o  = start_q;
    assign period_o = period_q;
    assign high_o   = high_q;
    assign count_o  = count_q;

endmodule

// File: rtl/ttl_gen_axi_lite_slave.sv
// rtl/ttl_gen_axi_lite_slave.sv - AXI4-Lite slave with independent write/read channel FSMs over the TTL register bank
module ttl_gen_axi_lite_slave
    import ttl_gen_axi_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 6,
    parameter logic [31:0] PERIOD_RST         = 32'd1000
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            ttl_enable,
    output logic                            ttl_start,
    output logic [31:0]                     ttl_period,
    output logic [31:0]                     ttl_high,
    output logic [31:0]                     ttl_count,
    input  logic                            ttl_busy,
    input  logic                            ttl_done
);

    w_state_e    w_state_q, w_state_d;
    r_state_e    r_state_q, r_state_d;
    logic        live_q;
    logic [3:0]  awidx_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  bresp_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    logic        aw_hs, w_hs, ar_hs;
    logic        wr_fire;
    logic [3:0]  wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [3:0]  rd_idx;
    logic [31:0] rf_rd_data;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // live_q keeps every READY low until the first clock after reset release.
    assign S_AXI_AWREADY = live_q && (w_state_q == W_IDLE || w_state_q == W_HAVE_D);
    assign S_AXI_WREADY  = live_q && (w_state_q == W_IDLE || w_state_q == W_HAVE_A);
    assign S_AXI_BVALID  = (w_state_q == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = live_q && (r_state_q == R_IDLE);
    assign S_AXI_RVALID  = (r_state_q == R_RESP);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // Take whichever half arrived earlier from the holding register, the other live.
    assign wr_idx  = (w_state_q == W_HAVE_A) ? awidx_q : S_AXI_AWADDR[5:2];
    assign wr_data = (w_state_q == W_HAVE_D) ? wdata_q : S_AXI_WDATA;
    assign wr_strb = (w_state_q == W_HAVE_D) ? wstrb_q : S_AXI_WSTRB;
    assign rd_idx  = S_AXI_ARADDR[5:2];

    always_comb begin
        w_state_d = w_state_q;
        wr_fire   = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    w_state_d = W_RESP;
                    wr_fire   = 1'b1;
                end else if (aw_hs) begin
                    w_state_d = W_HAVE_A;
                end else if (w_hs) begin
                    w_state_d = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                if (w_hs) begin
                    w_state_d = W_RESP;
                    wr_fire   = 1'b1;
                end
            end
            W_HAVE_D: begin
                if (aw_hs) begin
                    w_state_d = W_RESP;
                    wr_fire   = 1'b1;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE: if (ar_hs) r_state_d = R_RESP;
            R_RESP: if (S_AXI_RREADY) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            live_q    <= 1'b0;
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            live_q    <= 1'b1;
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            if (aw_hs) awidx_q <= S_AXI_AWADDR[5:2];
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (wr_fire) bresp_q <= idx_mapped(wr_idx) ? RESP_OKAY : RESP_SLVERR;
            // Read data is sampled before this edge's write lands, so a
            // same-cycle read sees the old value.
            if (ar_hs) begin
                rdata_q <= idx_mapped(rd_idx) ? rf_rd_data : 32'h0;
                rresp_q <= idx_mapped(rd_idx) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    ttl_gen_axi_regfile #(
        .PERIOD_RST (PERIOD_RST)
    ) u_regfile (
        .clk_i     (ACLK),
        .rst_ni    (ARESETN),
        .wr_en_i   (wr_fire && idx_mapped(wr_idx)),
        .wr_idx_i  (wr_idx[2:0]),
        .wr_data_i (wr_data),
        .wr_strb_i (wr_strb),
        .rd_idx_i  (rd_idx[2:0]),
        .rd_data_o (rf_rd_data),
        .busy_i    (ttl_busy),
        .done_i    (ttl_done),
        .enable_o  (ttl_enable),
        .start_o   (ttl_start),
        .period_o  (ttl_period),
        .high_o    (ttl_high),
        .count_o   (ttl_count)
    );

endmodule

// File: tb/tb_ttl_gen_axi_lite_slave.sv
// tb/tb_ttl_gen_axi_lite_slave.sv - directed self-checking bench for ttl_gen_axi_lite_slave
module tb_ttl_gen_axi_lite_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [5:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        ttl_enable, ttl_start;
    logic [31:0] ttl_period, ttl_high, ttl_count;
    logic        ttl_busy = 1'b0;
    logic        ttl_done = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;
    int start_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (ttl_start) start_cnt++;

    ttl_gen_axi_lite_slave dut (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .ttl_enable(ttl_enable), .ttl_start(ttl_start), .ttl_period(ttl_period),
        .ttl_high(ttl_high), .ttl_count(ttl_count), .ttl_busy(ttl_busy), .ttl_done(ttl_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic wait_bresp(output logic [1:0] resp);
        logic seen = 1'b0;
        bready = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bvalid) seen = 1'b1;
            else @(negedge clk);
        end
        check_eq("b_timeout", 32'(seen), 32'd1);
        resp = bresp;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        logic aw_go, w_go;
        @(negedge clk);
        awaddr = a; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int i = 0; i < 50 && (awvalid || wvalid); i++) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            @(posedge clk);
            @(negedge clk);
            if (aw_go) awvalid = 1'b0;
            if (w_go) wvalid = 1'b0;
        end
        check_eq("aw_w_timeout", 32'(awvalid || wvalid), 32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        wait_bresp(resp);
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic go = 1'b0;
        logic seen = 1'b0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 50 && !go; i++) begin
            go = arready;
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("ar_timeout", 32'(go), 32'd1);
        arvalid = 1'b0;
        rready = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (rvalid) seen = 1'b1;
            else @(negedge clk);
        end
        check_eq("r_timeout", 32'(seen), 32'd1);
        d = rdata; resp = rresp;
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
    endtask

    logic [31:0] rd;
    logic [1:0]  rs, ws;
    int          stray;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'({awready, wready, arready}), 32'd0);
        check_eq("rst_valid", 32'({bvalid, rvalid}), 32'd0);
        check_eq("rst_resp_data", rdata | 32'({bresp, rresp}), 32'd0);
        check_eq("rst_start", 32'(ttl_start), 32'd0);
        check_eq("rst_period", ttl_period, 32'd1000);
        rst_n = 1'b1;

        axi_read(6'h08, rd, rs);
        check_eq("period_rst_rdata", rd, 32'h0000_03E8);
        check_eq("period_rst_rresp", 32'(rs), 32'd0);

        // AW first, W three cycles later
        @(negedge clk);
        awaddr = 6'h0C; awvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        repeat (3) @(negedge clk);
        wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
        check_eq("split_wready", 32'(wready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        wvalid = 1'b0;
        check_eq("split_bvalid", 32'(bvalid), 32'd1);
        check_eq("split_bresp", 32'(bresp), 32'd0);
        check_eq("split_ttl_high", ttl_high, 32'h1234_5678);
        wait_bresp(ws);
        @(negedge clk);
        check_eq("split_bvalid_clr", 32'(bvalid), 32'd0);

        // Partial strobe
        axi_write(6'h14, 32'hAABB_CCDD, 4'h5, ws);
        check_eq("strb_bresp", 32'(ws), 32'd0);
        axi_read(6'h14, rd, rs);
        check_eq("strb_rdata", rd, 32'h00BB_00DD);

        // WSTRB=0 changes nothing but is OKAY
        axi_write(6'h10, 32'hFFFF_FFFF, 4'h0, ws);
        check_eq("strb0_bresp", 32'(ws), 32'd0);
        check_eq("strb0_count", ttl_count, 32'd0);

        // CTRL enable + start strobe
        start_cnt = 0;
        axi_write(6'h00, 32'h3, 4'hF, ws);
        repeat (4) @(negedge clk);
        check_eq("ctrl_enable", 32'(ttl_enable), 32'd1);
        check_eq("ctrl_start_cnt", 32'(start_cnt), 32'd1);
        axi_read(6'h00, rd, rs);
        check_eq("ctrl_rdata", rd, 32'h1);

        // STATUS readback and ignored write
        ttl_busy = 1'b1; ttl_done = 1'b0;
        axi_write(6'h04, 32'hFFFF_FFFF, 4'hF, ws);
        check_eq("status_wr_bresp", 32'(ws), 32'd0);
        axi_read(6'h04, rd, rs);
        check_eq("status_rdata", rd, 32'h1);

        // Unmapped write with BREADY held low
        @(negedge clk);
        awaddr = 6'h20; awvalid = 1'b1;
        wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("slverr_hold_%0d", i), 32'({bvalid, bresp}), 32'({1'b1, 2'b10}));
            check_eq($sformatf("slverr_awready_%0d", i), 32'(awready), 32'd0);
            @(negedge clk);
        end
        wait_bresp(ws);
        check_eq("slverr_ttl_high", ttl_high, 32'h1234_5678);
        check_eq("slverr_ttl_period", ttl_period, 32'd1000);
        axi_read(6'h3C, rd, rs);
        check_eq("unmapped_rresp", 32'(rs), 32'd2);
        check_eq("unmapped_rdata", rd, 32'h0);

        // Same-cycle write and read of PERIOD
        @(negedge clk);
        awaddr = 6'h08; awvalid = 1'b1;
        wdata = 32'd5; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 6'h08; arvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check_eq("rw_rvalid", 32'(rvalid), 32'd1);
        check_eq("rw_rdata_old", rdata, 32'd1000);
        check_eq("rw_bvalid", 32'(bvalid), 32'd1);
        check_eq("rw_period_new", ttl_period, 32'd5);
        bready = 1'b1; rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;

        // Reset while a write response is pending
        @(negedge clk);
        awaddr = 6'h18; awvalid = 1'b1;
        wdata = 32'h5555_AAAA; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check_eq("pre_rst_bvalid", 32'(bvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_bvalid_drop", 32'(bvalid), 32'd0);
        check_eq("rst_period_again", ttl_period, 32'd1000);
        @(negedge clk);
        rst_n = 1'b1;
        bready = 1'b1; rready = 1'b1;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bvalid || rvalid) stray++;
        end
        bready = 1'b0; rready = 1'b0;
        check_eq("no_resp_after_rst", 32'(stray), 32'd0);
        axi_read(6'h18, rd, rs);
        check_eq("scratch1_after_rst", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 0, 1);
        $fatal(1, "timeout");
    end

endmodule
